// File: rtl/bbot_quad_pkg.sv
// Shared types, defaults and the quadrature step decoder for bbot_quad_decoder.
package bbot_quad_pkg;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_FILTER_LEN = 4;
  localparam int DEF_ERR_CNT_W  = 8;

  typedef enum logic [1:0] {
    STEP_NONE    = 2'd0,
    STEP_UP      = 2'd1,
    STEP_DOWN    = 2'd2,
    STEP_ILLEGAL = 2'd3
  } step_e;

  // Next AB code in the up direction: 00 -> 10 -> 11 -> 01 -> 00 (AB = {A,B}).
  function automatic logic [1:0] quad_up_next(input logic [1:0] ab);
    logic [1:0] nxt;
    case (ab)
      2'b00:   nxt = 2'b10;
      2'b10:   nxt = 2'b11;
      2'b11:   nxt = 2'b01;
      default: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

  // Classify the transition between two successive filtered AB samples.
  function automatic step_e quad_decode(input logic [1:0] prev_ab,
                                        input logic [1:0] cur_ab);
    step_e st;
    if (prev_ab == cur_ab)
      st = STEP_NONE;
    else if ((prev_ab ^ cur_ab) == 2'b11)
      st = STEP_ILLEGAL;
    else if (quad_up_next(prev_ab) == cur_ab)
      st = STEP_UP;
    else
      st = STEP_DOWN;
    return st;
  endfunction

endpackage

// File: rtl/bbot_quad_filter.sv
// Two-flop synchronizer followed by a run-length debounce filter for one
// encoder pin. Reset preloads every stage with the live pin value.
module bbot_quad_filter
  import bbot_quad_pkg::*;
#(
  parameter int FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic clock,
  input  logic reset,
  input  logic i_raw,
  output logic o_filt
);

  localparam int RUN_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILTER_LEN - 1);

  logic             r_sync_p0;
  logic             r_sync_p1;
  logic             r_filt;
  logic [RUN_W-1:0] r_run;

  // Synchronize the pin, then accept it only after FILTER_LEN consecutive
  // disagreeing cycles; any agreeing cycle restarts the run.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync_p0 <= i_raw;
      r_sync_p1 <= i_raw;
      r_filt    <= i_raw;
      r_run     <= '0;
    end else begin
      r_sync_p0 <= i_raw;
      r_sync_p1 <= r_sync_p0;
      if (r_sync_p1 != r_filt) begin
        if (r_run == RUN_LAST) begin
          r_filt <= r_sync_p1;
          r_run  <= '0;
        end else begin
          r_run <= r_run + 1'b1;
        end
      end else begin
        r_run <= '0;
      end
    end
  end

  assign o_filt = r_filt;

endmodule

// File: rtl/bbot_quad_decoder.sv
// Quadrature encoder decoder: filtered A/B phases drive an up/down position
// counter with preload, sticky illegal-transition flag and saturating error
// counter. Define QUAD_INDEX_EN to add the index input and its capture logic.
module bbot_quad_decoder
  import bbot_quad_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int FILTER_LEN = DEF_FILTER_LEN,
  parameter int ERR_CNT_W  = DEF_ERR_CNT_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 A,
  input  logic                 B,
  input  logic                 enable,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_value,
  input  logic                 err_clr,
`ifdef QUAD_INDEX_EN
  input  logic                 I,
  output logic [WIDTH-1:0]     index_count,
  output logic                 index_valid,
`endif
  output logic [WIDTH-1:0]     count,
  output logic                 direction,
  output logic                 error,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [WIDTH-1:0] COUNT_RST = {1'b1, {(WIDTH-1){1'b0}}};

  logic                 w_filt_a;
  logic                 w_filt_b;
  logic [1:0]           w_cur_ab;
  step_e                w_step;
  logic                 w_illegal;
  logic [WIDTH-1:0]     w_count_nxt;
  logic                 w_dir_nxt;

  logic [1:0]           r_prev_ab;
  logic [WIDTH-1:0]     r_count;
  logic                 r_dir;
  logic                 r_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  bbot_quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clock  (clock),
    .reset  (reset),
    .i_raw  (A),
    .o_filt (w_filt_a)
  );

  bbot_quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clock  (clock),
    .reset  (reset),
    .i_raw  (B),
    .o_filt (w_filt_b)
  );

  assign w_cur_ab  = {w_filt_a, w_filt_b};
  assign w_step    = quad_decode(r_prev_ab, w_cur_ab);
  assign w_illegal = (w_step == STEP_ILLEGAL);

  // Next count/direction: load wins and swallows any coincident step.
  always_comb begin
    w_count_nxt = r_count;
    w_dir_nxt   = r_dir;
    if (load) begin
      w_count_nxt = load_value;
    end else if (enable) begin
      if (w_step == STEP_UP) begin
        w_count_nxt = r_count + 1'b1;
        w_dir_nxt   = 1'b1;
      end else if (w_step == STEP_DOWN) begin
        w_count_nxt = r_count - 1'b1;
        w_dir_nxt   = 1'b0;
      end
    end
  end

  // Position, direction and error state; previous AB tracks every cycle so
  // steps taken while disabled are absorbed rather than replayed later.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_prev_ab <= {A, B};
      r_count   <= COUNT_RST;
      r_dir     <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_prev_ab <= w_cur_ab;
      r_count   <= w_count_nxt;
      r_dir     <= w_dir_nxt;
      if (w_illegal)
        r_err <= 1'b1;
      else if (err_clr)
        r_err <= 1'b0;
      if (w_illegal && (r_err_cnt != '1))
        r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign count     = r_count;
  assign direction = r_dir;
  assign error     = r_err;
  assign err_count = r_err_cnt;

`ifdef QUAD_INDEX_EN
  logic             w_filt_i;
  logic             r_i_prev;
  logic [WIDTH-1:0] r_idx_cnt;
  logic             r_idx_vld;

  bbot_quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_i (
    .clock  (clock),
    .reset  (reset),
    .i_raw  (I),
    .o_filt (w_filt_i)
  );

  // Capture the count being written on each filtered index rising edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_i_prev  <= I;
      r_idx_cnt <= '0;
      r_idx_vld <= 1'b0;
    end else begin
      r_i_prev  <= w_filt_i;
      r_idx_vld <= w_filt_i & ~r_i_prev;
      if (w_filt_i & ~r_i_prev)
        r_idx_cnt <= w_count_nxt;
    end
  end

  assign index_count = r_idx_cnt;
  assign index_valid = r_idx_vld;
`endif

endmodule

// File: tb/tb_bbot_quad_decoder.sv
// Self-checking bench for bbot_quad_decoder (WIDTH=32, FILTER_LEN=4).
// Index checks are included when QUAD_INDEX_EN is defined.
module tb_bbot_quad_decoder;

  logic        clock = 1'b0;
  logic        reset;
  logic        A, B, enable, load, err_clr;
  logic [31:0] load_value;
  logic [31:0] count;
  logic        direction, error;
  logic [7:0]  err_count;
`ifdef QUAD_INDEX_EN
  logic        I;
  logic [31:0] index_count;
  logic        index_valid;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  bbot_quad_decoder #(.WIDTH(32), .FILTER_LEN(4), .ERR_CNT_W(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .A          (A),
    .B          (B),
    .enable     (enable),
    .load       (load),
    .load_value (load_value),
    .err_clr    (err_clr),
`ifdef QUAD_INDEX_EN
    .I          (I),
    .index_count(index_count),
    .index_valid(index_valid),
`endif
    .count      (count),
    .direction  (direction),
    .error      (error),
    .err_count  (err_count)
  );

  typedef struct {
    logic        a, b, en, ld;
    logic [31:0] ldv;
    logic        clr;
    logic [31:0] e_cnt;
    logic        e_dir, e_err;
    logic [7:0]  e_ecnt;
  } vec_t;

  vec_t tv[14];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic negs(input int n);
    repeat (n) @(negedge clock);
  endtask

  logic [1:0] up_seq[4];
  logic [31:0] c0;
  logic        changed;
  int          pulses;
  logic [31:0] cap;

  initial begin
    up_seq[0] = 2'b00; up_seq[1] = 2'b10; up_seq[2] = 2'b11; up_seq[3] = 2'b01;

    //           a     b     en    ld    ldv           clr   e_cnt         dir   err   ecnt
    tv[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h80000007, 1'b0, 1'b0, 8'd0};
    tv[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h80000006, 1'b0, 1'b0, 8'd0};
    tv[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h80000007, 1'b1, 1'b0, 8'd0};
    tv[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h80000007, 1'b1, 1'b0, 8'd0};
    tv[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h80000007, 1'b1, 1'b0, 8'd0};
    tv[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 8'd0};
    tv[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h00000000, 1'b1, 1'b0, 8'd0};
    tv[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 8'd0};
    tv[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        1'b0, 32'h00000000, 1'b0, 1'b0, 8'd0};
    tv[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 8'd0};
    tv[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, 8'd1};
    tv[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 8'd1};
    tv[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, 8'd2};
    tv[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 8'd2};

    reset = 1'b1; A = 1'b0; B = 1'b0; enable = 1'b1; load = 1'b0;
    load_value = 32'h0; err_clr = 1'b0;
`ifdef QUAD_INDEX_EN
    I = 1'b0;
`endif
    negs(3);
    reset = 1'b0;
    negs(2);
    check("reset count", count, 32'h80000000);
    check("reset direction", {31'b0, direction}, 32'd0);
    check("reset error", {31'b0, error}, 32'd0);
    check("reset err_count", {24'b0, err_count}, 32'd0);
`ifdef QUAD_INDEX_EN
    check("reset index_count", index_count, 32'd0);
    check("reset index_valid", {31'b0, index_valid}, 32'd0);
`endif

    // Eight up steps, 10 cycles apart, with exact latency check.
    for (int i = 0; i < 8; i++) begin
      {A, B} = up_seq[(i + 1) % 4];
      for (int k = 1; k <= 10; k++) begin
        @(negedge clock);
        if (k == 6) check($sformatf("latency step%0d before", i), count, 32'h80000000 + i);
        if (k == 7) check($sformatf("latency step%0d after", i), count, 32'h80000001 + i);
      end
    end
    check("8 ups count", count, 32'h80000008);
    check("8 ups direction", {31'b0, direction}, 32'd1);

    // Table-driven vectors.
    for (int i = 0; i < 14; i++) begin
      A = tv[i].a; B = tv[i].b; enable = tv[i].en;
      load = tv[i].ld; load_value = tv[i].ldv; err_clr = tv[i].clr;
      negs(1);
      load = 1'b0; err_clr = 1'b0;
      negs(9);
      check($sformatf("row%0d count", i), count, tv[i].e_cnt);
      check($sformatf("row%0d direction", i), {31'b0, direction}, {31'b0, tv[i].e_dir});
      check($sformatf("row%0d error", i), {31'b0, error}, {31'b0, tv[i].e_err});
      check($sformatf("row%0d err_count", i), {24'b0, err_count}, {24'b0, tv[i].e_ecnt});
    end

    // Move to AB=00 (up from 01): count wraps to 0.
    {A, B} = 2'b00;
    negs(10);
    check("to 00 count", count, 32'h0);

    // 3-cycle glitch on A is rejected.
    c0 = count; changed = 1'b0;
    A = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clock);
      if (k == 3) A = 1'b0;
      if (count !== c0) changed = 1'b1;
    end
    check("glitch3 no change", {31'b0, changed}, 32'd0);
    check("glitch3 count", count, c0);

    // 4-cycle pulse on A: one up then one down.
    A = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clock);
      if (k == 4) A = 1'b0;
      if (k == 6)  check("pulse4 pre", count, 32'h0);
      if (k == 7)  check("pulse4 up", count, 32'h1);
      if (k == 7)  check("pulse4 up dir", {31'b0, direction}, 32'd1);
      if (k == 10) check("pulse4 hold", count, 32'h1);
      if (k == 11) check("pulse4 down", count, 32'h0);
      if (k == 11) check("pulse4 down dir", {31'b0, direction}, 32'd0);
    end

    // Illegal 00->11 with err_clr in the same cycle as detection.
    {A, B} = 2'b11;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clock);
      if (k == 6) err_clr = 1'b1;
    end
    err_clr = 1'b0;
    check("clr+illegal error", {31'b0, error}, 32'd1);
    check("clr+illegal err_count", {24'b0, err_count}, 32'd3);
    check("clr+illegal count", count, 32'h0);
    err_clr = 1'b1;
    negs(1);
    err_clr = 1'b0;
    negs(1);
    check("clr alone error", {31'b0, error}, 32'd0);
    check("clr alone err_count", {24'b0, err_count}, 32'd3);
    negs(8);

    // Load coincident with an up step (11->01): load wins, step lost.
    {A, B} = 2'b01;
    for (int k = 1; k <= 6; k++) @(negedge clock);
    check("ld+step pre", count, 32'h0);
    load = 1'b1; load_value = 32'h12345678;
    negs(1);
    load = 1'b0;
    check("ld+step count", count, 32'h12345678);
    negs(8);
    check("ld+step later", count, 32'h12345678);

    // err_count saturation via repeated illegal 01<->10 toggles.
    for (int i = 0; i < 260; i++) begin
      {A, B} = (i % 2 == 0) ? 2'b10 : 2'b01;
      negs(8);
    end
    negs(4);
    check("sat err_count", {24'b0, err_count}, 32'd255);
    check("sat error", {31'b0, error}, 32'd1);
    check("sat count", count, 32'h12345678);

    // Reset in the middle of a pending filter run, together with load.
    {A, B} = 2'b11;
    negs(3);
    reset = 1'b1; load = 1'b1; load_value = 32'hDEADBEEF; err_clr = 1'b1;
    negs(1);
    reset = 1'b0; load = 1'b0; err_clr = 1'b0;
    negs(12);
    check("midreset count", count, 32'h80000000);
    check("midreset direction", {31'b0, direction}, 32'd0);
    check("midreset error", {31'b0, error}, 32'd0);
    check("midreset err_count", {24'b0, err_count}, 32'd0);

`ifdef QUAD_INDEX_EN
    // Five up steps from 11, then an index rising edge.
    for (int i = 0; i < 5; i++) begin
      {A, B} = up_seq[(i + 3) % 4];
      negs(10);
    end
    check("idx pre count", count, 32'h80000005);
    I = 1'b1;
    pulses = 0; cap = 32'h0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clock);
      if (index_valid) begin
        pulses++;
        cap = index_count;
      end
    end
    check("idx pulses", pulses, 32'd1);
    check("idx captured", cap, 32'h80000005);
    check("idx held", index_count, 32'h80000005);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
